// File: rtl/traffic_lamp_driver_if.sv
// Lamp-driver bus: upstream indications and operator clear in, six lamps and fault status out.
// When TLD_FAULT_COUNT_EN is defined the bus also carries the 8-bit fault_count.
interface traffic_lamp_driver_if;
   logic       NSG_LED;
   logic       EWG_LED;
   logic       yellow_LED;
   logic       fault_clr;
   logic       ns_red;
   logic       ns_amber;
   logic       ns_green;
   logic       ew_red;
   logic       ew_amber;
   logic       ew_green;
   logic       fault;
`ifdef TLD_FAULT_COUNT_EN
   logic [7:0] fault_count;

   modport master (
      output NSG_LED, EWG_LED, yellow_LED, fault_clr,
      input  ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, fault, fault_count
   );

   modport slave (
      input  NSG_LED, EWG_LED, yellow_LED, fault_clr,
      output ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, fault, fault_count
   );
`else
   modport master (
      output NSG_LED, EWG_LED, yellow_LED, fault_clr,
      input  ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, fault
   );

   modport slave (
      input  NSG_LED, EWG_LED, yellow_LED, fault_clr,
      output ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, fault
   );
`endif
endinterface

// File: rtl/traffic_lamp_driver.sv
// Traffic lamp driver: maps upstream controller indications onto six lamps,
// inserts an all-red clearance before every change of green direction and
// latches a flashing-amber fail-safe on conflicting indications.
// Optional feature macro: TLD_FAULT_COUNT_EN (adds a saturating 8-bit fault entry counter).
module traffic_lamp_driver #(
   parameter int CLEAR_CYCLES = 3,
   parameter int FLASH_HALF   = 4
) (
   input logic              clk,
   input logic              reset,
   traffic_lamp_driver_if.slave lamps
);

   typedef enum logic [1:0] {ST_RUN, ST_CLEAR, ST_FAULT} state_t;
   typedef enum logic {DIR_NS, DIR_EW} dir_t;

   // Lamp vector order: {ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green}
   localparam logic [5:0] LAMP_ALL_RED  = 6'b100_100;
   localparam logic [5:0] LAMP_NS_GREEN = 6'b001_100;
   localparam logic [5:0] LAMP_NS_AMBER = 6'b010_100;
   localparam logic [5:0] LAMP_EW_GREEN = 6'b100_001;
   localparam logic [5:0] LAMP_EW_AMBER = 6'b100_010;

   localparam logic [7:0] CLEAR_INIT = 8'(CLEAR_CYCLES - 1);
   localparam logic [7:0] FLASH_LAST = 8'(FLASH_HALF - 1);

   state_t     state_q, state_d;
   dir_t       last_dir_q, last_dir_d;
   dir_t       pend_q, pend_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] flash_cnt_q, flash_cnt_d;
   logic       flash_q, flash_d;
   logic [5:0] lamp_q, lamp_d;
   logic       fault_q;
   logic       fault_entry;
   logic       invalid;

   // More than one upstream indication at once is a conflict
   assign invalid = (lamps.NSG_LED & lamps.EWG_LED) |
                    (lamps.NSG_LED & lamps.yellow_LED) |
                    (lamps.EWG_LED & lamps.yellow_LED);

   // Next-state, counters and next lamp pattern
   always_comb begin
      state_d     = state_q;
      last_dir_d  = last_dir_q;
      pend_d      = pend_q;
      cnt_d       = cnt_q;
      flash_d     = flash_q;
      flash_cnt_d = flash_cnt_q;
      lamp_d      = LAMP_ALL_RED;
      fault_entry = 1'b0;

      if (invalid) begin
         // Conflict wins over everything else, including fault_clr
         state_d = ST_FAULT;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (lamps.NSG_LED) begin
                  if (last_dir_q == DIR_NS) begin
                     lamp_d = LAMP_NS_GREEN;
                  end else begin
                     state_d = ST_CLEAR;
                     cnt_d   = CLEAR_INIT;
                     pend_d  = DIR_NS;
                  end
               end else if (lamps.EWG_LED) begin
                  if (last_dir_q == DIR_EW) begin
                     lamp_d = LAMP_EW_GREEN;
                  end else begin
                     state_d = ST_CLEAR;
                     cnt_d   = CLEAR_INIT;
                     pend_d  = DIR_EW;
                  end
               end else if (lamps.yellow_LED) begin
                  lamp_d = (last_dir_q == DIR_NS) ? LAMP_NS_AMBER : LAMP_EW_AMBER;
               end
            end
            ST_CLEAR: begin
               // Clearance always runs to completion, even if the green request drops
               if (cnt_q == 8'd0) begin
                  state_d    = ST_RUN;
                  last_dir_d = pend_q;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            ST_FAULT: begin
               if (lamps.fault_clr) begin
                  state_d = ST_CLEAR;
                  cnt_d   = CLEAR_INIT;
                  pend_d  = last_dir_q;
               end
            end
            default: begin
               state_d = ST_RUN;
            end
         endcase
      end

      if (state_d == ST_FAULT) begin
         if (state_q != ST_FAULT) begin
            // Fresh entry: amber starts lit, half-period timer restarts
            fault_entry = 1'b1;
            flash_d     = 1'b1;
            flash_cnt_d = 8'd0;
         end else if (flash_cnt_q >= FLASH_LAST) begin
            flash_d     = ~flash_q;
            flash_cnt_d = 8'd0;
         end else begin
            flash_cnt_d = flash_cnt_q + 8'd1;
         end
         lamp_d = {1'b0, flash_d, 1'b0, 1'b0, flash_d, 1'b0};
      end
   end

   // State, counters and registered lamp outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_RUN;
         last_dir_q  <= DIR_NS;
         pend_q      <= DIR_NS;
         cnt_q       <= 8'd0;
         flash_cnt_q <= 8'd0;
         flash_q     <= 1'b0;
         lamp_q      <= LAMP_ALL_RED;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_dir_q  <= last_dir_d;
         pend_q      <= pend_d;
         cnt_q       <= cnt_d;
         flash_cnt_q <= flash_cnt_d;
         flash_q     <= flash_d;
         lamp_q      <= lamp_d;
         fault_q     <= (state_d == ST_FAULT);
      end
   end

   assign lamps.ns_red   = lamp_q[5];
   assign lamps.ns_amber = lamp_q[4];
   assign lamps.ns_green = lamp_q[3];
   assign lamps.ew_red   = lamp_q[2];
   assign lamps.ew_amber = lamp_q[1];
   assign lamps.ew_green = lamp_q[0];
   assign lamps.fault    = fault_q;

`ifdef TLD_FAULT_COUNT_EN
   logic [7:0] fault_count_q;

   // Count entries into FAULT from RUN/CLEAR, holding at 255; only reset clears it
   always_ff @(posedge clk) begin
      if (reset) begin
         fault_count_q <= 8'd0;
      end else if (fault_entry && (fault_count_q != 8'hFF)) begin
         fault_count_q <= fault_count_q + 8'd1;
      end
   end

   assign lamps.fault_count = fault_count_q;
`else
   logic unused_fault_entry;
   assign unused_fault_entry = fault_entry;
`endif

endmodule
